// File: rtl/leitor_registrador7b.sv
// Read-side walker for the 7-bit register bank: addresses each word, captures it and
// sends it as a UART-like frame on tx. Define LEITOR_PARITY_EN to add an even-parity bit.
module leitor_registrador7b #(
  parameter  int NREG = 4,
  parameter  int DIV  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iniciar,
  input  logic [6:0]    valores_registrador,
  output logic [AW-1:0] endereco,
  output logic          tx,
  output logic          ocupado,
  output logic          fim
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [AW-1:0] END_MAX = AW'(NREG - 1);

`ifdef LEITOR_PARITY_EN
  typedef enum logic [2:0] {
    OCIOSO, ENDERECA, CAPTURA, INICIO, DADOS, PARIDADE, PARADA
  } estado_t;
`else
  typedef enum logic [2:0] {
    OCIOSO, ENDERECA, CAPTURA, INICIO, DADOS, PARADA
  } estado_t;
`endif

  estado_t       estado, proximo;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    deslocamento;
  logic          fim_bit;
  logic          ultimo;
  logic          contando;
  logic          tx_d;
`ifdef LEITOR_PARITY_EN
  logic          paridade;
`endif

  assign fim_bit  = (div_cnt == DIV_MAX);
  assign ultimo   = (endereco == END_MAX);
  assign ocupado  = (estado != OCIOSO);
  assign contando = (estado == INICIO) || (estado == DADOS) ||
`ifdef LEITOR_PARITY_EN
                    (estado == PARIDADE) ||
`endif
                    (estado == PARADA);

  // NOTE: reset is in the sensitivity list so an abort takes effect without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= proximo;
  end

  // NOTE: proximo and tx_d get defaults first so no path through the case infers a latch.
  always_comb begin
    proximo = estado;
    tx_d    = 1'b1;
    case (estado)
      OCIOSO:   if (iniciar) proximo = ENDERECA;
      ENDERECA: proximo = CAPTURA;
      CAPTURA:  proximo = INICIO;
      INICIO: begin
        tx_d = 1'b0;
        if (fim_bit) proximo = DADOS;
      end
      DADOS: begin
        tx_d = deslocamento[0];
`ifdef LEITOR_PARITY_EN
        if (fim_bit && bit_cnt == 3'd6) proximo = PARIDADE;
      end
      PARIDADE: begin
        tx_d = paridade;
        if (fim_bit) proximo = PARADA;
      end
`else
        if (fim_bit && bit_cnt == 3'd6) proximo = PARADA;
      end
`endif
      PARADA:   if (fim_bit) proximo = ultimo ? OCIOSO : ENDERECA;
      default:  proximo = OCIOSO;
    endcase
  end

  // NOTE: all sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx           <= 1'b1;
      fim          <= 1'b0;
      endereco     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      deslocamento <= '0;
    end else begin
      tx  <= tx_d;
      fim <= (estado == PARADA) && fim_bit && ultimo;

      if (contando) div_cnt <= fim_bit ? '0 : div_cnt + DW'(1);
      else          div_cnt <= '0;

      if (estado == DADOS && fim_bit)
        bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;

      // The frame is built from this private copy, so later bank writes cannot disturb it.
      if (estado == CAPTURA)
        deslocamento <= valores_registrador;
      else if (estado == DADOS && fim_bit)
        deslocamento <= deslocamento >> 1;

      if (estado == OCIOSO && iniciar)
        endereco <= '0;
      else if (estado == PARADA && fim_bit)
        endereco <= ultimo ? '0 : endereco + AW'(1);
    end
  end

`ifdef LEITOR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    paridade <= 1'b0;
    else if (estado == CAPTURA) paridade <= ^valores_registrador;
  end
`endif

endmodule

// File: tb/tb_leitor_registrador7b.sv
// Scoreboard bench for leitor_registrador7b: stimulus queues expected frames and fim times,
// a negedge UART-style receiver decodes tx and checks them against the queues.
module tb_leitor_registrador7b;

  localparam int NREG = 4;
  localparam int DIV  = 4;
  localparam int AW   = $clog2(NREG);
`ifdef LEITOR_PARITY_EN
  localparam int FB = 10;
`else
  localparam int FB = 9;
`endif
  localparam int PER  = 2 + FB * DIV;
  localparam int WALK = NREG * PER;

  typedef struct {
    logic [6:0] data;
    int         addr;
    int         cyc;
  } frame_t;

  frame_t exp_q[$];
  int     fim_q[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          iniciar;
  logic [6:0]    valores;
  logic [AW-1:0] endereco;
  logic          tx, ocupado, fim;
  logic [6:0]    bank [NREG];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  leitor_registrador7b #(.NREG(NREG), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .valores_registrador(valores),
    .endereco(endereco), .tx(tx), .ocupado(ocupado), .fim(fim)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always_comb valores = bank[endereco];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [9:0] expected_frame(input logic [6:0] d);
`ifdef LEITOR_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b01, d, 1'b0};
`endif
  endfunction

  // Receiver / scoreboard
  bit         rx_active = 0;
  int         rx_cnt    = 0;
  logic [9:0] rx_bits;
  frame_t     cur;
  int         ocu_cnt   = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
      ocu_cnt   = 0;
    end else begin
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
        rx_bits   = '0;
        check("frame_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("frame_start_cycle", cyc, cur.cyc);
          check("frame_address", 32'(endereco), cur.addr);
        end else begin
          cur = '{data: 7'h0, addr: -1, cyc: -1};
        end
      end
      if (rx_active) begin
        if (rx_cnt % DIV == DIV / 2) begin
          rx_bits[rx_cnt / DIV] = tx;
          if (rx_cnt / DIV == FB - 1) begin
            if (cur.addr >= 0) check("frame_bits", 32'(rx_bits), 32'(expected_frame(cur.data)));
            rx_active = 0;
          end
        end
        rx_cnt++;
      end
      if (fim) begin
        check("fim_queue_nonempty", 32'(fim_q.size() != 0), 1);
        if (fim_q.size() != 0) check("fim_cycle", cyc, fim_q.pop_front());
        check("ocupado_cycles", ocu_cnt, WALK);
        ocu_cnt = 0;
      end
      if (ocupado) ocu_cnt++;
    end
  end

  task automatic push_walk(input int c0);
    for (int i = 0; i < NREG; i++)
      exp_q.push_back('{data: bank[i], addr: i, cyc: c0 + 3 + i * PER});
    fim_q.push_back(c0 + WALK);
  endtask

  task automatic start_walk(output int c0);
    @(negedge clk);
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_walk(c0);
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic noise(input int c0);
    repeat (4) begin
      repeat ($urandom_range(3, 25)) @(negedge clk);
      if (cyc + 2 < c0 + WALK) begin
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fim_q.size() != 0) && n < 3 * WALK) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size() + fim_q.size()), 0);
    exp_q.delete();
    fim_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bank    = '{7'h55, 7'h01, 7'h7F, 7'h00};
    iniciar = 1'b0;
    rst     = 1'b1;
    #1;
    check("reset_tx", tx, 1);
    check("reset_ocupado", ocupado, 0);
    check("reset_fim", fim, 0);
    check("reset_endereco", 32'(endereco), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (20) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_ocupado", ocupado, 0);
      check("idle_fim", fim, 0);
      check("idle_endereco", 32'(endereco), 0);
    end

    // Directed walk over the reference bank
    start_walk(c0);
    drain();

    // Start requests during a walk must be ignored
    start_walk(c0);
    noise(c0);
    drain();

    // Word 0 rewritten while its data bits are on the line
    start_walk(c0);
    wait_cyc(c0 + 3 + DIV + 2);
    bank[0] = 7'h2A;
    drain();
    bank[0] = 7'h55;

    // iniciar held high: second walk begins on the edge after fim
    @(negedge clk);
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_walk(c0);
    push_walk(c0 + WALK + 1);
    repeat (WALK + 1) @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    drain();

    // Reset during register 2's data bits
    start_walk(c0);
    wait_cyc(c0 + 3 + 2 * PER + DIV + 2);
    check("pre_reset_endereco", 32'(endereco), 2);
    #2;
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_ocupado", ocupado, 0);
    check("abort_endereco", 32'(endereco), 0);
    check("abort_fim", fim, 0);
    exp_q.delete();
    fim_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("post_reset_tx", tx, 1);
      check("post_reset_ocupado", ocupado, 0);
    end
    start_walk(c0);
    drain();

    // Randomized banks, some walks with spurious start requests
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREG; i++) bank[i] = 7'($urandom_range(0, 127));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      start_walk(c0);
      if (r % 2 == 1) noise(c0);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
